// File: rtl/multicycle_ctrl_hs_if.sv
// Instruction/data bus handshake and datapath-control bundle between the
// multi-cycle RV32I controller (master) and the core datapath/bus side (slave).
interface multicycle_ctrl_hs_if;
    logic [31:0] instrCode;
    logic        instrReady;
    logic        dataReady;
    logic        trapClear;

    logic        instrReq;
    logic        irWe;
    logic        PCEn;
    logic        regFileWe;
    logic [3:0]  aluControl;
    logic        aluSrcMuxSel;
    logic [2:0]  LoadSizeMuxSel;
    logic        busRe;
    logic        busWe;
    logic [1:0]  StoreSizeMuxSel;
    logic [2:0]  RFWDSrcMuxSel;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        trap;
    logic [1:0]  trapCause;

    modport master (
        input  instrCode, instrReady, dataReady, trapClear,
        output instrReq, irWe, PCEn, regFileWe, aluControl, aluSrcMuxSel,
               LoadSizeMuxSel, busRe, busWe, StoreSizeMuxSel, RFWDSrcMuxSel,
               branch, jal, jalr, trap, trapCause
    );

    modport slave (
        output instrCode, instrReady, dataReady, trapClear,
        input  instrReq, irWe, PCEn, regFileWe, aluControl, aluSrcMuxSel,
               LoadSizeMuxSel, busRe, busWe, StoreSizeMuxSel, RFWDSrcMuxSel,
               branch, jal, jalr, trap, trapCause
    );
endinterface

// File: rtl/multicycle_ctrl_hs.sv
// RV32I multi-cycle control FSM with ready-handshaked instruction/data bus
// wait states, a per-wait-state bus timeout and illegal-instruction trapping.
module multicycle_ctrl_hs #(
    parameter int unsigned BUS_TIMEOUT  = 15,
    parameter bit          ILLEGAL_TRAP = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    multicycle_ctrl_hs_if.master bus
);

    localparam int unsigned   CW       = (BUS_TIMEOUT > 0) ? $clog2(BUS_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

    typedef enum logic [3:0] {
        FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE,
        S_EXE, S_MEM, L_EXE, L_MEM, L_WB, TRAP
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_IBUS    = 2'b10,
        CAUSE_DBUS    = 2'b11
    } cause_t;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111
    } opcode_t;

    state_t        state;
    state_t        state_next;
    state_t        decode_target;
    cause_t        cause;
    cause_t        cause_next;
    logic [CW-1:0] cnt;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [3:0] operator;
    logic       illegal;
    logic       in_wait;
    logic       ready;
    logic       timeout_hit;

    assign opcode   = bus.instrCode[6:0];
    assign funct3   = bus.instrCode[14:12];
    assign operator = {bus.instrCode[30], funct3};

    always_comb begin
        decode_target = FETCH;
        illegal       = 1'b0;
        case (opcode)
            OP_REG:    decode_target = R_EXE;
            OP_IMM:    decode_target = I_EXE;
            OP_BRANCH: decode_target = B_EXE;
            OP_LUI:    decode_target = LU_EXE;
            OP_AUIPC:  decode_target = AU_EXE;
            OP_JAL:    decode_target = J_EXE;
            OP_JALR: begin
                decode_target = JL_EXE;
                illegal       = (funct3 != 3'b000);
            end
            OP_STORE: begin
                decode_target = S_EXE;
                illegal       = (funct3 > 3'b010);
            end
            OP_LOAD: begin
                decode_target = L_EXE;
                illegal       = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            default:   illegal = 1'b1;
        endcase
    end

    // One shared counter serves all three wait states; any state change clears it.
    assign in_wait     = (state == FETCH) || (state == S_MEM) || (state == L_MEM);
    assign ready       = (state == FETCH) ? bus.instrReady : bus.dataReady;
    assign timeout_hit = (BUS_TIMEOUT != 0) && !ready && (cnt == CNT_LAST);

    always_comb begin
        state_next = state;
        cause_next = cause;
        case (state)
            FETCH: begin
                if (bus.instrReady) begin
                    state_next = DECODE;
                end else if (timeout_hit) begin
                    state_next = TRAP;
                    cause_next = CAUSE_IBUS;
                end
            end
            DECODE: begin
                if (!illegal) begin
                    state_next = decode_target;
                end else if (ILLEGAL_TRAP) begin
                    state_next = TRAP;
                    cause_next = CAUSE_ILLEGAL;
                end else begin
                    state_next = FETCH;
                end
            end
            R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE, L_WB: state_next = FETCH;
            S_EXE: state_next = S_MEM;
            L_EXE: state_next = L_MEM;
            S_MEM: begin
                if (bus.dataReady) begin
                    state_next = FETCH;
                end else if (timeout_hit) begin
                    state_next = TRAP;
                    cause_next = CAUSE_DBUS;
                end
            end
            L_MEM: begin
                if (bus.dataReady) begin
                    state_next = L_WB;
                end else if (timeout_hit) begin
                    state_next = TRAP;
                    cause_next = CAUSE_DBUS;
                end
            end
            TRAP: begin
                if (bus.trapClear) begin
                    state_next = FETCH;
                    cause_next = CAUSE_NONE;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            cause <= CAUSE_NONE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cause <= cause_next;
            if (state_next != state) begin
                cnt <= '0;
            end else if (in_wait && !ready) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign bus.trapCause = cause;

    // Outputs are decoded from state; reset forces the FETCH request pattern with irWe held off.
    always_comb begin
        bus.instrReq        = 1'b0;
        bus.irWe            = 1'b0;
        bus.PCEn            = 1'b0;
        bus.regFileWe       = 1'b0;
        bus.aluControl      = 4'b0000;
        bus.aluSrcMuxSel    = 1'b0;
        bus.LoadSizeMuxSel  = 3'b000;
        bus.busRe           = 1'b0;
        bus.busWe           = 1'b0;
        bus.StoreSizeMuxSel = 2'b00;
        bus.RFWDSrcMuxSel   = 3'b000;
        bus.branch          = 1'b0;
        bus.jal             = 1'b0;
        bus.jalr            = 1'b0;
        bus.trap            = 1'b0;
        if (!reset) begin
            bus.instrReq = 1'b1;
        end else begin
            case (state)
                FETCH: begin
                    bus.instrReq = 1'b1;
                    bus.irWe     = bus.instrReady;
                end
                DECODE: bus.PCEn = illegal && !ILLEGAL_TRAP;
                R_EXE: begin
                    bus.regFileWe  = 1'b1;
                    bus.aluControl = operator;
                    bus.PCEn       = 1'b1;
                end
                I_EXE: begin
                    bus.regFileWe    = 1'b1;
                    bus.aluSrcMuxSel = 1'b1;
                    bus.aluControl   = (funct3 == 3'b101) ? operator : {1'b0, funct3};
                    bus.PCEn         = 1'b1;
                end
                B_EXE: begin
                    bus.branch     = 1'b1;
                    bus.aluControl = operator;
                    bus.PCEn       = 1'b1;
                end
                LU_EXE: begin
                    bus.regFileWe     = 1'b1;
                    bus.RFWDSrcMuxSel = 3'b010;
                    bus.PCEn          = 1'b1;
                end
                AU_EXE: begin
                    bus.regFileWe     = 1'b1;
                    bus.RFWDSrcMuxSel = 3'b011;
                    bus.PCEn          = 1'b1;
                end
                J_EXE: begin
                    bus.regFileWe     = 1'b1;
                    bus.RFWDSrcMuxSel = 3'b100;
                    bus.jal           = 1'b1;
                    bus.PCEn          = 1'b1;
                end
                JL_EXE: begin
                    bus.regFileWe     = 1'b1;
                    bus.RFWDSrcMuxSel = 3'b100;
                    bus.jal           = 1'b1;
                    bus.jalr          = 1'b1;
                    bus.PCEn          = 1'b1;
                end
                S_EXE: bus.aluSrcMuxSel = 1'b1;
                S_MEM: begin
                    bus.aluSrcMuxSel    = 1'b1;
                    bus.busWe           = 1'b1;
                    bus.StoreSizeMuxSel = funct3[1:0];
                    bus.PCEn            = bus.dataReady;
                end
                L_EXE: begin
                    bus.aluSrcMuxSel  = 1'b1;
                    bus.RFWDSrcMuxSel = 3'b001;
                end
                L_MEM: begin
                    bus.aluSrcMuxSel  = 1'b1;
                    bus.RFWDSrcMuxSel = 3'b001;
                    bus.busRe         = 1'b1;
                end
                L_WB: begin
                    bus.regFileWe      = 1'b1;
                    bus.aluSrcMuxSel   = 1'b1;
                    bus.RFWDSrcMuxSel  = 3'b001;
                    bus.LoadSizeMuxSel = funct3;
                    bus.PCEn           = 1'b1;
                end
                TRAP: bus.trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_hs.sv
// Bench for multicycle_ctrl_hs: table vectors, hand-written corner sequences and
// random instructions/wait states checked against an instruction-level model.
module tb_multicycle_ctrl_hs;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_ctrl_hs_if ifa ();
    multicycle_ctrl_hs_if ifb ();

    multicycle_ctrl_hs #(.BUS_TIMEOUT(4), .ILLEGAL_TRAP(1'b1)) dut_trap (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    multicycle_ctrl_hs #(.BUS_TIMEOUT(0), .ILLEGAL_TRAP(1'b0)) dut_nop (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    typedef struct packed {
        logic       instrReq;
        logic       irWe;
        logic       PCEn;
        logic       regFileWe;
        logic [3:0] aluControl;
        logic       aluSrc;
        logic [2:0] loadSize;
        logic       busRe;
        logic       busWe;
        logic [1:0] storeSize;
        logic [2:0] rfwd;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       trap;
        logic [1:0] trapCause;
    } outs_t;

    typedef struct {
        logic  ir;
        logic  dr;
        logic  tc;
        outs_t o;
    } cyc_t;
    typedef cyc_t cq_t[$];

    typedef struct {
        logic [31:0] ins;
        int          lat;
        outs_t       fin;
    } vec_t;

    localparam int C_R = 0, C_I = 1, C_B = 2, C_LUI = 3, C_AUI = 4, C_JAL = 5,
                   C_JALR = 6, C_S = 7, C_L = 8, C_ILL = 9;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic outs_t mk(bit pc, bit we, logic [3:0] alu, bit src, logic [2:0] lsz,
                                 bit re, bit wr, logic [1:0] ssz, logic [2:0] rfwd,
                                 bit br, bit j, bit jr);
        outs_t o;
        o = '0;
        o.PCEn = pc; o.regFileWe = we; o.aluControl = alu; o.aluSrc = src;
        o.loadSize = lsz; o.busRe = re; o.busWe = wr; o.storeSize = ssz;
        o.rfwd = rfwd; o.branch = br; o.jal = j; o.jalr = jr;
        return o;
    endfunction

    function automatic cyc_t cy(logic ir, logic dr, logic tc, outs_t o);
        cyc_t c;
        c.ir = ir; c.dr = dr; c.tc = tc; c.o = o;
        return c;
    endfunction

    function automatic outs_t sample(input bit sel);
        if (!sel)
            return {ifa.instrReq, ifa.irWe, ifa.PCEn, ifa.regFileWe, ifa.aluControl,
                    ifa.aluSrcMuxSel, ifa.LoadSizeMuxSel, ifa.busRe, ifa.busWe,
                    ifa.StoreSizeMuxSel, ifa.RFWDSrcMuxSel, ifa.branch, ifa.jal,
                    ifa.jalr, ifa.trap, ifa.trapCause};
        return {ifb.instrReq, ifb.irWe, ifb.PCEn, ifb.regFileWe, ifb.aluControl,
                ifb.aluSrcMuxSel, ifb.LoadSizeMuxSel, ifb.busRe, ifb.busWe,
                ifb.StoreSizeMuxSel, ifb.RFWDSrcMuxSel, ifb.branch, ifb.jal,
                ifb.jalr, ifb.trap, ifb.trapCause};
    endfunction

    function automatic int classify(input logic [31:0] ins);
        case (ins[6:0])
            7'h33: return C_R;
            7'h13: return C_I;
            7'h63: return C_B;
            7'h37: return C_LUI;
            7'h17: return C_AUI;
            7'h6F: return C_JAL;
            7'h67: return (ins[14:12] == 3'd0) ? C_JALR : C_ILL;
            7'h23: return (ins[14:12] <= 3'd2) ? C_S : C_ILL;
            7'h03: return (ins[14:12] == 3'd3 || ins[14:12] >= 3'd6) ? C_ILL : C_L;
            default: return C_ILL;
        endcase
    endfunction

    function automatic logic [6:0] pick_op(input int k);
        case (k)
            0: return 7'h33;  1: return 7'h13;  2: return 7'h63;  3: return 7'h37;
            4: return 7'h17;  5: return 7'h6F;  6: return 7'h67;  7: return 7'h23;
            8: return 7'h03;  9: return 7'h7F;  10: return 7'h0F;
            default: return 7'h73;
        endcase
    endfunction

    // Whole-instruction cycle script: per-cycle ready/clear inputs and expected outputs.
    task automatic build(input logic [31:0] ins, input int fw, input int mw,
                         input bit itrap, input int tmo, output cq_t q);
        outs_t f, o, m, t;
        int    cls;
        logic [2:0] f3;
        f3 = ins[14:12];
        q  = {};
        f  = '0; f.instrReq = 1'b1;
        if (tmo != 0 && fw >= tmo) begin
            for (int i = 0; i < tmo; i++) q.push_back(cy(1'b0, 1'b0, 1'b0, f));
            t = '0; t.trap = 1'b1; t.trapCause = 2'b10;
            q.push_back(cy(1'b0, 1'b0, 1'b1, t));
            return;
        end
        for (int i = 0; i < fw; i++) q.push_back(cy(1'b0, 1'b0, 1'b0, f));
        o = f; o.irWe = 1'b1;
        q.push_back(cy(1'b1, 1'b0, 1'b0, o));
        cls = classify(ins);
        o = '0;
        if (cls == C_ILL) begin
            if (itrap) begin
                q.push_back(cy(1'b0, 1'b0, 1'b0, o));
                t = '0; t.trap = 1'b1; t.trapCause = 2'b01;
                q.push_back(cy(1'b0, 1'b0, 1'b1, t));
            end else begin
                o.PCEn = 1'b1;
                q.push_back(cy(1'b0, 1'b0, 1'b0, o));
            end
            return;
        end
        q.push_back(cy(1'b0, 1'b0, 1'b0, o));
        case (cls)
            C_R:    o = mk(1, 1, {ins[30], f3}, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            C_I:    o = mk(1, 1, (f3 == 3'b101) ? {ins[30], f3} : {1'b0, f3}, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            C_B:    o = mk(1, 0, {ins[30], f3}, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            C_LUI:  o = mk(1, 1, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0);
            C_AUI:  o = mk(1, 1, 0, 0, 0, 0, 0, 0, 3'b011, 0, 0, 0);
            C_JAL:  o = mk(1, 1, 0, 0, 0, 0, 0, 0, 3'b100, 0, 1, 0);
            C_JALR: o = mk(1, 1, 0, 0, 0, 0, 0, 0, 3'b100, 0, 1, 1);
            default: begin
                o = (cls == C_S) ? mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)
                                 : mk(0, 0, 0, 1, 0, 0, 0, 0, 3'b001, 0, 0, 0);
                q.push_back(cy(1'b0, 1'b0, 1'b0, o));
                m = o;
                if (cls == C_S) begin m.busWe = 1'b1; m.storeSize = ins[13:12]; end
                else m.busRe = 1'b1;
                if (tmo != 0 && mw >= tmo) begin
                    for (int i = 0; i < tmo; i++) q.push_back(cy(1'b0, 1'b0, 1'b0, m));
                    t = '0; t.trap = 1'b1; t.trapCause = 2'b11;
                    q.push_back(cy(1'b0, 1'b0, 1'b1, t));
                    return;
                end
                for (int i = 0; i < mw; i++) q.push_back(cy(1'b0, 1'b0, 1'b0, m));
                if (cls == C_S) begin
                    m.PCEn = 1'b1;
                    q.push_back(cy(1'b0, 1'b1, 1'b0, m));
                    return;
                end
                q.push_back(cy(1'b0, 1'b1, 1'b0, m));
                o = mk(1, 1, 0, 1, f3, 0, 0, 0, 3'b001, 0, 0, 0);
            end
        endcase
        q.push_back(cy(1'b0, 1'b0, 1'b0, o));
    endtask

    task automatic drive(input bit sel, input logic [31:0] ins, input logic ir, input logic dr, input logic tc);
        ifa.instrCode = ins; ifb.instrCode = ins;
        ifa.instrReady = sel ? 1'b0 : ir;  ifb.instrReady = sel ? ir : 1'b0;
        ifa.dataReady  = sel ? 1'b0 : dr;  ifb.dataReady  = sel ? dr : 1'b0;
        ifa.trapClear  = sel ? 1'b0 : tc;  ifb.trapClear  = sel ? tc : 1'b0;
    endtask

    task automatic exec(input bit sel, input logic [31:0] ins, input int fw, input int mw,
                        output int lat, output outs_t last);
        cq_t   q;
        outs_t act;
        build(ins, fw, mw, !sel, sel ? 0 : 4, q);
        last = '0;
        foreach (q[i]) begin
            drive(sel, ins, q[i].ir, q[i].dr, q[i].tc);
            @(negedge clk);
            act = sample(sel);
            check($sformatf("%s ins=%h fw=%0d mw=%0d cyc%0d", sel ? "nop" : "trap", ins, fw, mw, i),
                  32'(act), 32'(q[i].o));
            last = act;
            @(posedge clk); #1;
        end
        lat = q.size();
        drive(sel, ins, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        outs_t rst_o;
        rst_o = '0; rst_o.instrReq = 1'b1;
        ifa.instrReady = 1'b1; ifb.instrReady = 1'b1;
        ifa.dataReady = 1'b1;  ifb.dataReady = 1'b1;
        ifa.trapClear = 1'b0;  ifb.trapClear = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("reset_state_a", 32'(sample(1'b0)), 32'(rst_o));
        check("reset_state_b", 32'(sample(1'b1)), 32'(rst_o));
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vec_t        tbl[14];
        int          lat;
        outs_t       last, act, idle_o;
        logic [31:0] ins;

        tbl[0]  = '{32'h002081B3, 3, mk(1, 1, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{32'h402081B3, 3, mk(1, 1, 4'h8, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{32'h00500093, 3, mk(1, 1, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[3]  = '{32'h4030D093, 3, mk(1, 1, 4'hD, 1, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[4]  = '{32'h40004093, 3, mk(1, 1, 4'h4, 1, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[5]  = '{32'h00000063, 3, mk(1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0)};
        tbl[6]  = '{32'h000010B7, 3, mk(1, 1, 4'h0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0)};
        tbl[7]  = '{32'h00001097, 3, mk(1, 1, 4'h0, 0, 0, 0, 0, 0, 3'b011, 0, 0, 0)};
        tbl[8]  = '{32'h000000EF, 3, mk(1, 1, 4'h0, 0, 0, 0, 0, 0, 3'b100, 0, 1, 0)};
        tbl[9]  = '{32'h000100E7, 3, mk(1, 1, 4'h0, 0, 0, 0, 0, 0, 3'b100, 0, 1, 1)};
        tbl[10] = '{32'h00208023, 4, mk(1, 0, 4'h0, 1, 0, 0, 1, 2'b00, 0, 0, 0, 0)};
        tbl[11] = '{32'h0020A023, 4, mk(1, 0, 4'h0, 1, 0, 0, 1, 2'b10, 0, 0, 0, 0)};
        tbl[12] = '{32'h00011083, 5, mk(1, 1, 4'h0, 1, 3'b001, 0, 0, 0, 3'b001, 0, 0, 0)};
        tbl[13] = '{32'h00014083, 5, mk(1, 1, 4'h0, 1, 3'b100, 0, 0, 0, 3'b001, 0, 0, 0)};
        idle_o = '0; idle_o.instrReq = 1'b1;

        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        do_reset();

        foreach (tbl[i]) begin
            exec(1'b0, tbl[i].ins, 0, 0, lat, last);
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
            check($sformatf("tbl%0d_final", i), 32'(last), 32'(tbl[i].fin));
        end

        exec(1'b0, 32'h002081B3, 4, 0, lat, last);
        check("ifetch_timeout_cause", 32'(last.trapCause), 32'd2);
        exec(1'b0, 32'h002081B3, 3, 0, lat, last);
        check("ifetch_edge_latency", 32'(lat), 32'd6);
        exec(1'b0, 32'h00208023, 0, 3, lat, last);
        check("sb_edge_latency", 32'(lat), 32'd7);
        check("sb_edge_no_trap", 32'(last.trap), 32'd0);
        exec(1'b0, 32'h00208023, 0, 4, lat, last);
        check("sb_timeout_cause", 32'(last.trapCause), 32'd3);
        exec(1'b0, 32'h00011083, 1, 4, lat, last);
        check("lh_timeout_cause", 32'(last.trapCause), 32'd3);
        exec(1'b0, 32'h0000007F, 0, 0, lat, last);
        check("illegal_op_cause", 32'(last.trapCause), 32'd1);
        exec(1'b0, 32'h00013083, 0, 0, lat, last);
        exec(1'b0, 32'h0020B023, 0, 0, lat, last);
        exec(1'b0, 32'h000110E7, 0, 0, lat, last);

        // Reset landing in S_MEM must drop busWe immediately.
        drive(1'b0, 32'h00208023, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 32'h00208023, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        act = sample(1'b0);
        check("rst_mid_busWe_before", 32'(act.busWe), 32'd1);
        #2 reset = 1'b0;
        #1 act = sample(1'b0);
        check("rst_mid_during", 32'(act), 32'(idle_o));
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_after", 32'(sample(1'b0)), 32'(idle_o));
        do_reset();

        for (int n = 0; n < 80; n++) begin
            ins = $urandom;
            ins[6:0] = pick_op(int'($urandom_range(0, 11)));
            exec(1'b0, ins, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), lat, last);
        end

        do_reset();
        exec(1'b1, 32'h0000007F, 0, 0, lat, last);
        check("nop_illegal_latency", 32'(lat), 32'd2);
        check("nop_illegal_pcen", 32'(last), 32'(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        exec(1'b1, 32'h00011083, 0, 4, lat, last);
        check("lh_wait4_latency", 32'(lat), 32'd9);
        check("lh_wait4_final", 32'(last), 32'(tbl[12].fin));
        exec(1'b1, 32'h00208023, 7, 6, lat, last);
        check("no_timeout_latency", 32'(lat), 32'd17);
        for (int n = 0; n < 40; n++) begin
            ins = $urandom;
            ins[6:0] = pick_op(int'($urandom_range(0, 11)));
            exec(1'b1, ins, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), lat, last);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired act=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_ctrl_hs.md
# multicycle_ctrl_hs

Parametrised successor to the RV32I multi-cycle control FSM. It sequences FETCH/DECODE/EXE/MEM/WB for RV32I base integer instructions, adds ready-handshaked instruction and data bus accesses with wait states, a bus timeout, and illegal-instruction detection with a trap state. It sits between the instruction register/bus interface and the datapath muxes of the multi-cycle core.

## Interface
- BUS_TIMEOUT, 15: max consecutive cycles with ready low in one bus wait state before trapping; 0 disables timeout.
- ILLEGAL_TRAP, 1: 1 = illegal encoding enters TRAP; 0 = illegal encoding retires as a NOP (PC+4).
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instrCode  in  32  current instruction register contents.
- instrReady  in  1  instruction bus has valid data this cycle.
- dataReady  in  1  data bus completes the read/write this cycle.
- trapClear  in  1  leave TRAP, restart at FETCH.
- instrReq  out  1  instruction fetch request.
- irWe  out  1  latch instruction register.
- PCEn  out  1  PC update (commit).
- regFileWe  out  1  register file write.
- aluControl  out  4  ALU op.
- aluSrcMuxSel  out  1  0 = rs2, 1 = immediate.
- LoadSizeMuxSel  out  3  load extension select (funct3).
- busRe / busWe  out  1 each  data bus read / write strobe.
- StoreSizeMuxSel  out  2  00 byte, 01 half, 10 word.
- RFWDSrcMuxSel  out  3  000 ALU, 001 load, 010 LUI imm, 011 AUIPC, 100 PC+4.
- branch / jal / jalr  out  1 each  next-PC select qualifiers.
- trap  out  1  high while in TRAP.
- trapCause  out  2  00 none, 01 illegal, 10 instr bus timeout, 11 data bus timeout; registered, held until trapClear or reset.

## Operation
- States: FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE, S_EXE, S_MEM, L_EXE, L_MEM, L_WB, TRAP.
- operator = {instrCode[30], instrCode[14:12]}.
- FETCH: instrReq=1. When instrReady=1: irWe=1, go to DECODE. Otherwise stay.
- DECODE: dispatch on opcode to the matching EXE state. Illegal cases:
  - unknown opcode
  - load funct3 ∈ {011,110,111}
  - store funct3 > 010
  - JALR funct3≠000
  - With an illegal encoding: ILLEGAL_TRAP=1 → TRAP, cause 01. ILLEGAL_TRAP=0 → PCEn=1 (branch/jal/jalr=0), go to FETCH.
- R_EXE: regFileWe=1, aluControl=operator, PCEn=1.
- I_EXE: regFileWe=1, aluSrc=1, PCEn=1. aluControl=operator if funct3=101, else {0,funct3}.
- B_EXE: branch=1, aluControl=operator, PCEn=1.
- LU_EXE / AU_EXE: regFileWe=1, RFWD=010 / 011, PCEn=1.
- J_EXE: regFileWe=1, RFWD=100, jal=1, PCEn=1.
- JL_EXE: regFileWe=1, RFWD=100, jal=1, jalr=1, PCEn=1.
- All single-EXE states return to FETCH.
- S_EXE: aluSrc=1, go to S_MEM.
- S_MEM: aluSrc=1, busWe=1, StoreSize from funct3. When dataReady=1: PCEn=1, go to FETCH.
- L_EXE: aluSrc=1, RFWD=001, go to L_MEM.
- L_MEM: aluSrc=1, RFWD=001, busRe=1. When dataReady=1: go to L_WB.
- L_WB: regFileWe=1, aluSrc=1, RFWD=001, LoadSize=funct3, PCEn=1, go to FETCH.
- Timeout, in wait states FETCH, S_MEM, L_MEM:
  - counter, width $clog2(BUS_TIMEOUT+1), cleared on entry to each wait state.
  - increments each cycle with ready low.
  - if ready is low while counter==BUS_TIMEOUT-1 → TRAP; cause 10 from FETCH, 11 from S_MEM/L_MEM.
  - ready high in that same cycle wins: normal completion, no trap.
- TRAP: every enable/strobe is 0 and trap=1. trapClear=1 → FETCH, trapCause cleared to 00.
- Unlisted outputs default to 0; aluControl defaults to 0000 (ADD).

## Timing
- Reset asserted: state=FETCH, counter=0, trapCause=00.
  - Outputs during reset: instrReq=1, all others 0, aluControl=0000.
  - Reset mid-operation aborts immediately; busWe/busRe/regFileWe drop asynchronously.
- Zero-wait latency in cycles: ALU/branch/jump/LUI/AUIPC = 3, store = 4, load = 5. Each ready-low cycle adds one.
- Exactly one PCEn pulse per retired instruction, in its final cycle. No PCEn in TRAP.
- Handshake strobes:
  - busWe stays high every S_MEM cycle until dataReady; address and data stay stable.
  - busRe behaves the same way in L_MEM.
  - instrReq stays high until instrReady.
- Outputs are combinational from state and instrCode; only state, counter and trapCause are registered.

## Test plan
- ADD x3,x1,x2 (0x002081B3), instrReady=1, dataReady=1 → FETCH→DECODE→R_EXE in 3 cycles; aluControl=0000, regFileWe=1 and PCEn=1 in cycle 3.
- LH (funct3=001) with dataReady held low 4 cycles in L_MEM → L_MEM lasts 5 cycles with busRe=1 throughout; L_WB has LoadSizeMuxSel=001, regFileWe=1; total latency 9.
- BUS_TIMEOUT=4, instrReady held low → trap=1 after the 4th FETCH cycle, trapCause=10, no irWe. trapClear=1 → FETCH, trapCause=00.
- Opcode 0x7F with ILLEGAL_TRAP=1 → TRAP, trapCause=01. Same with ILLEGAL_TRAP=0 → PCEn=1 in DECODE, back to FETCH.
- SB (funct3=000) → S_MEM with StoreSize=00, busWe=1; dataReady rises on the same cycle the counter hits BUS_TIMEOUT-1 → completes, no trap.
- reset asserted while in S_MEM with busWe=1 → busWe=0 immediately, state FETCH, instrReq=1 after release.
